// File: rtl/updown_mod_counter_pkg.sv
// Shared counter definitions: mode constants and the binary-to-Gray helper.
package counter_pkg;

    // Boundary behaviour selector for the SAT parameter
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Gray code of a binary value; callers cast down to their own width.
    // Upper bits of a zero-extended input stay zero, so truncation is exact.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for the up/down modulo counter.
interface updown_mod_counter_if #(
    parameter int K = 3
);
    // Control, driven by the counter's user
    logic         en;
    logic         up;
    logic         ld;
    logic [K-1:0] ld_val;

    // Status, driven by the counter
    logic [K-1:0] cnt_out;
    logic [K-1:0] cnt_gray;
    logic         lap;
    logic         ovf;
    logic         udf;
    logic         at_max;
    logic         at_min;

    modport master (
        output en, up, ld, ld_val,
        input  cnt_out, cnt_gray, lap, ovf, udf, at_max, at_min
    );

    modport slave (
        input  en, up, ld, ld_val,
        output cnt_out, cnt_gray, lap, ovf, udf, at_max, at_min
    );

endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate mode, lap bit and a
// registered Gray copy of the count. One next-state block feeds one
// register block; every output except at_max/at_min is registered.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int K   = 3,
    parameter int MOD = 2 ** K,
    parameter int SAT = CNT_WRAP
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);

    // Reject illegal configurations at elaboration
    generate
        if (MOD < 2 || MOD > 2 ** K) begin : g_bad_mod
            $error("updown_mod_counter: MOD must satisfy 2 <= MOD <= 2**K");
        end
        if (SAT != CNT_WRAP && SAT != CNT_SAT) begin : g_bad_sat
            $error("updown_mod_counter: SAT must be CNT_WRAP or CNT_SAT");
        end
    endgenerate

    // Largest legal count; every computed next value stays at or below it,
    // so arithmetic at width K never needs a carry bit.
    localparam logic [K-1:0] MAXV  = K'(MOD - 1);
    localparam logic         W_SAT = (SAT == CNT_SAT);

    logic [K-1:0] r_cnt;
    logic [K-1:0] r_gray;
    logic         r_lap;
    logic         r_ovf;
    logic         r_udf;

    logic [K-1:0] w_nxt;
    logic [K-1:0] w_nxt_gray;
    logic         w_lap_nxt;
    logic         w_ovf_nxt;
    logic         w_udf_nxt;
    logic         w_at_max;
    logic         w_at_min;

    assign w_at_max = (r_cnt == MAXV);
    assign w_at_min = (r_cnt == '0);

    // Next-state: load beats count; boundary steps wrap or hold per SAT
    always_comb begin
        w_nxt     = r_cnt;
        w_lap_nxt = r_lap;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
        if (bus.ld) begin
            w_nxt = (bus.ld_val > MAXV) ? MAXV : bus.ld_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_max) begin
                    w_ovf_nxt = 1'b1;
                    if (!W_SAT) begin
                        w_nxt     = '0;
                        w_lap_nxt = ~r_lap;
                    end
                end else begin
                    w_nxt = r_cnt + 1'b1;
                end
            end else begin
                if (w_at_min) begin
                    w_udf_nxt = 1'b1;
                    if (!W_SAT) begin
                        w_nxt     = MAXV;
                        w_lap_nxt = ~r_lap;
                    end
                end else begin
                    w_nxt = r_cnt - 1'b1;
                end
            end
        end
    end

    // Gray copy is derived from the next value so it lands on the same edge
    assign w_nxt_gray = K'(bin2gray(32'(w_nxt)));

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_gray <= '0;
            r_lap  <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            r_gray <= w_nxt_gray;
            r_lap  <= w_lap_nxt;
            r_ovf  <= w_ovf_nxt;
            r_udf  <= w_udf_nxt;
        end
    end

    assign bus.cnt_out  = r_cnt;
    assign bus.cnt_gray = r_gray;
    assign bus.lap      = r_lap;
    assign bus.ovf      = r_ovf;
    assign bus.udf      = r_udf;
    assign bus.at_max   = w_at_max;
    assign bus.at_min   = w_at_min;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: wrap (MOD=6), saturate (MOD=6) and power-of-two (MOD=16)
// counters driven from vector tables plus a gapped power-of-two sweep.
module tb_updown_mod_counter;
    import counter_pkg::*;

    logic clk;
    logic rst_w, rst_s, rst_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_mod_counter_if #(.K(3)) bw ();
    updown_mod_counter_if #(.K(3)) bs ();
    updown_mod_counter_if #(.K(4)) bp ();

    updown_mod_counter #(.K(3), .MOD(6),  .SAT(CNT_WRAP)) u_wrap (.clk(clk), .rst(rst_w), .bus(bw));
    updown_mod_counter #(.K(3), .MOD(6),  .SAT(CNT_SAT))  u_sat  (.clk(clk), .rst(rst_s), .bus(bs));
    updown_mod_counter #(.K(4), .MOD(16), .SAT(CNT_WRAP)) u_pow2 (.clk(clk), .rst(rst_p), .bus(bp));

    // One vector: inputs applied before an edge, outputs expected after it
    typedef struct {
        logic       rst, en, up, ld;
        logic [2:0] ld_val;
        logic [2:0] cnt, gray;
        logic       lap, ovf, udf, amax, amin;
    } vec_t;

    vec_t vw[$];
    vec_t vs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, e, u, l, input logic [2:0] lv,
                                input logic [2:0] c, g, input logic lp, o, un, mx, mn);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.ld_val = lv;
        v.cnt = c; v.gray = g; v.lap = lp; v.ovf = o; v.udf = un; v.amax = mx; v.amin = mn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    int prev_cnt, mcnt, incs, cyc, toggles;
    logic mlap, prev_lap;
    logic [3:0] prev_gray, mgray;
    logic go;

    initial begin
        // ---- wrap table (MOD=6): r en up ld lv | cnt gray lap ovf udf max min
        vw.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,1)); // reset
        vw.push_back(mk(0,1,1,0,0, 1,1,0,0,0,0,0));
        vw.push_back(mk(0,1,1,0,0, 2,3,0,0,0,0,0));
        vw.push_back(mk(0,1,1,0,0, 3,2,0,0,0,0,0));
        vw.push_back(mk(0,1,1,0,0, 4,6,0,0,0,0,0));
        vw.push_back(mk(0,1,1,0,0, 5,7,0,0,0,1,0));
        vw.push_back(mk(0,1,1,0,0, 0,0,1,1,0,0,1)); // 5->0 wrap
        vw.push_back(mk(0,1,1,0,0, 1,1,1,0,0,0,0)); // ovf clears
        vw.push_back(mk(0,1,0,0,0, 0,0,1,0,0,0,1));
        vw.push_back(mk(0,1,0,0,0, 5,7,0,0,1,1,0)); // 0->5 wrap down
        vw.push_back(mk(0,1,0,0,0, 4,6,0,0,0,0,0)); // udf clears
        vw.push_back(mk(0,1,1,1,7, 5,7,0,0,0,1,0)); // load clamp beats en
        vw.push_back(mk(0,1,1,1,2, 2,3,0,0,0,0,0)); // load at max with en: no ovf
        vw.push_back(mk(0,0,0,1,0, 0,0,0,0,0,0,1));
        vw.push_back(mk(0,1,0,0,0, 5,7,1,0,1,1,0));
        vw.push_back(mk(0,1,0,0,0, 4,6,1,0,0,0,0)); // cnt=4 lap=1
        vw.push_back(mk(1,1,1,1,3, 0,0,0,0,0,0,1)); // reset beats ld/en
        vw.push_back(mk(0,1,1,0,0, 1,1,0,0,0,0,0));
        vw.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,0)); // idle hold
        vw.push_back(mk(0,1,1,0,0, 2,3,0,0,0,0,0)); // direction flips
        vw.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        vw.push_back(mk(0,1,1,0,0, 2,3,0,0,0,0,0));

        // ---- saturate table (MOD=6)
        vs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,1));
        vs.push_back(mk(0,0,0,1,5, 5,7,0,0,0,1,0));
        vs.push_back(mk(0,1,1,0,0, 5,7,0,1,0,1,0));
        vs.push_back(mk(0,1,1,0,0, 5,7,0,1,0,1,0));
        vs.push_back(mk(0,1,1,0,0, 5,7,0,1,0,1,0));
        vs.push_back(mk(0,0,1,0,0, 5,7,0,0,0,1,0));
        vs.push_back(mk(0,1,0,0,0, 4,6,0,0,0,0,0));
        vs.push_back(mk(0,1,1,1,6, 5,7,0,0,0,1,0)); // clamp
        vs.push_back(mk(0,0,0,1,0, 0,0,0,0,0,0,1));
        vs.push_back(mk(0,1,0,0,0, 0,0,0,0,1,0,1));
        vs.push_back(mk(0,1,0,0,0, 0,0,0,0,1,0,1)); // held udf
        vs.push_back(mk(0,1,1,0,0, 1,1,0,0,0,0,0));

        rst_w = 1'b1; rst_s = 1'b1; rst_p = 1'b1;
        bw.en = 0; bw.up = 0; bw.ld = 0; bw.ld_val = '0;
        bs.en = 0; bs.up = 0; bs.ld = 0; bs.ld_val = '0;
        bp.en = 0; bp.up = 0; bp.ld = 0; bp.ld_val = '0;
        @(posedge clk); #1;

        foreach (vw[i]) begin
            rst_w = vw[i].rst; bw.en = vw[i].en; bw.up = vw[i].up;
            bw.ld = vw[i].ld; bw.ld_val = vw[i].ld_val;
            @(posedge clk); #1;
            chk($sformatf("wrap[%0d]", i),
                16'({bw.cnt_out, bw.cnt_gray, bw.lap, bw.ovf, bw.udf, bw.at_max, bw.at_min}),
                16'({vw[i].cnt, vw[i].gray, vw[i].lap, vw[i].ovf, vw[i].udf, vw[i].amax, vw[i].amin}));
        end
        bw.en = 0; bw.ld = 0; rst_w = 0;

        foreach (vs[i]) begin
            rst_s = vs[i].rst; bs.en = vs[i].en; bs.up = vs[i].up;
            bs.ld = vs[i].ld; bs.ld_val = vs[i].ld_val;
            @(posedge clk); #1;
            chk($sformatf("sat[%0d]", i),
                16'({bs.cnt_out, bs.cnt_gray, bs.lap, bs.ovf, bs.udf, bs.at_max, bs.at_min}),
                16'({vs[i].cnt, vs[i].gray, vs[i].lap, vs[i].ovf, vs[i].udf, vs[i].amax, vs[i].amin}));
        end
        bs.en = 0; bs.ld = 0; rst_s = 0;

        // ---- power-of-two sweep with random enable gaps
        rst_p = 1'b0;
        chk("pow2_reset", 16'({bp.cnt_out, bp.cnt_gray, bp.lap}), 16'd0);
        mcnt = 0; mlap = 1'b0; incs = 0; cyc = 0; toggles = 0;
        prev_gray = bp.cnt_gray; prev_lap = bp.lap; prev_cnt = 0;
        bp.up = 1'b1;
        while (incs < 40 && cyc < 400) begin
            go = ($urandom_range(0, 2) != 0);
            bp.en = go;
            @(posedge clk); #1;
            cyc++;
            if (go) begin
                incs++;
                if (mcnt == 15) begin
                    mcnt = 0; mlap = ~mlap;
                end else begin
                    mcnt = mcnt + 1;
                end
            end
            mgray = 4'(mcnt) ^ (4'(mcnt) >> 1);
            chk("pow2_cnt", 16'(bp.cnt_out), 16'(mcnt));
            chk("pow2_gray", 16'(bp.cnt_gray), 16'(mgray));
            chk("pow2_lap", 16'(bp.lap), 16'(mlap));
            if (32'(bp.cnt_out) != prev_cnt)
                chk("pow2_gray_1bit", 16'($countones(bp.cnt_gray ^ prev_gray)), 16'd1);
            if (bp.lap != prev_lap) toggles++;
            prev_gray = bp.cnt_gray; prev_lap = bp.lap; prev_cnt = 32'(bp.cnt_out);
        end
        bp.en = 1'b0;
        chk("pow2_incs_done", 16'(incs), 16'd40);
        chk("pow2_lap_toggles", 16'(toggles), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter: the next-generation counter primitive for the FIFO datapath, used for read/write pointers and occupancy tracking. It adds direction control, a synchronous parallel load, arbitrary modulo, a wrap or saturate mode, a lap bit and a registered Gray-coded copy of the count. All state is registered on one clock; the lap bit and Gray output let FIFO full/empty and clock-crossing logic be built on top without extra pointer registers.

## Interface

- K, 3: counter width in bits.
- MOD, 2**K: count range is 0..MOD-1. Legal range is 2 ≤ MOD ≤ 2**K. Any other value is an elaboration error.
- SAT, 0: 0 = wrap mode, 1 = saturate mode.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  count enable; steps the counter by one.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- ld  in  1  synchronous load.
- ld_val  in  K  load value.
- cnt_out  out  K  registered binary count.
- cnt_gray  out  K  registered Gray code of cnt_out.
- lap  out  1  registered; toggles on every wrap in either direction.
- ovf  out  1  registered one-cycle pulse on an attempted increment at MOD-1.
- udf  out  1  registered one-cycle pulse on an attempted decrement at 0.
- at_max  out  1  combinational; cnt_out == MOD-1.
- at_min  out  1  combinational; cnt_out == 0.

## Operation

- Priority per edge is rst > ld > en.
- **rst=1**
  - cnt_out, cnt_gray, lap, ovf and udf all go to 0.
- **ld=1**
  - cnt_out ← min(ld_val, MOD-1).
  - lap is unchanged; ovf=udf=0.
  - en and up are ignored.
- **en=1, up=1, cnt_out < MOD-1:** cnt_out+1.
- **en=1, up=1, cnt_out == MOD-1**
  - SAT=0: cnt_out ← 0, lap toggles.
  - SAT=1: cnt_out holds, lap unchanged.
  - In both modes, ovf=1 for that cycle.
- **en=1, up=0, cnt_out > 0:** cnt_out-1.
- **en=1, up=0, cnt_out == 0**
  - SAT=0: cnt_out ← MOD-1, lap toggles.
  - SAT=1: cnt_out holds.
  - In both modes, udf=1.
- **en=0 and ld=0:** all state holds; ovf=udf=0.
- ovf and udf are never both 1. Each clears on the next edge unless the condition repeats; continuous en at a saturated boundary gives a continuously high pulse.
- cnt_gray is computed from the next binary value (n ^ (n>>1)) and registered on the same edge as cnt_out. It is therefore never skewed from cnt_out.
- Arithmetic is done at width K. No intermediate value may exceed MOD-1, so no K+1-bit carry leaks into cnt_out.
- When MOD is not a power of two, the Gray transition across the wrap changes more than one bit. This is legal, and users needing single-bit CDC steps must use MOD = 2**K.

## Timing

- Latency is 1 cycle from en, ld or rst to cnt_out, cnt_gray, lap, ovf and udf.
- at_max and at_min are valid in the same cycle as cnt_out; they are decoded combinationally from the register.
- Reset mid-count takes effect at the next edge regardless of en or ld, and ovf/udf are low the cycle after.
- ld together with en at a boundary: the load wins, and there is no ovf/udf and no lap toggle.
- Back-to-back en is supported: one step per cycle, no bubbles.
- Direction may change every cycle without penalty.

## Structure

- Shared package counter_pkg holds:
  - constants CNT_WRAP=0 and CNT_SAT=1;
  - function bin2gray(K-bit).
- No sub-module is needed. Next-state logic is one combinational block feeding one registered block.
- The existing plain counter stays as is; this block does not instantiate it.

## Test plan

- **Wrap up.** K=3, MOD=6, SAT=0. Reset, then en=1, up=1 for 7 cycles → cnt_out 1,2,3,4,5,0,1. ovf high only on the 5→0 edge, lap=1 after it, cnt_gray 1,3,2,6,7,0,1.
- **Wrap down.** K=3, MOD=6, from 0: en=1, up=0 → cnt_out=5, udf pulse, lap toggles. Next cycle cnt_out=4, udf=0.
- **Saturate.** K=3, MOD=6, SAT=1. Load 5, then en=1, up=1 for 3 cycles → cnt_out stays 5, ovf=1 each cycle, lap=0, at_max=1.
- **Load clamp and priority.** ld=1, ld_val=7 with MOD=6 and en=1, up=1 → cnt_out=5, ovf=0, lap unchanged.
- **Reset mid-operation.** At cnt_out=4, lap=1, assert rst with en=1 and ld=1 → next cycle all outputs 0. Releasing rst with en=1 gives cnt_out=1.
- **Power-of-two wrap.** K=4, MOD=16, SAT=0. Count through 15→0 with random en gaps → every cnt_gray change is exactly one bit, and lap toggles once per 16 increments.
